// File: rtl/approx_error_monitor_if.sv
// rtl/approx_error_monitor_if.sv - sample handshake bundle: operands plus approximate product
interface approx_error_monitor_if #(
    parameter int WIDTH = 4
);
    logic               s_valid;
    logic               s_ready;
    logic [WIDTH-1:0]   s_in1;
    logic [WIDTH-1:0]   s_in2;
    logic [2*WIDTH-1:0] s_approx;

    modport master (
        output s_valid, s_in1, s_in2, s_approx,
        input  s_ready
    );

    modport slave (
        input  s_valid, s_in1, s_in2, s_approx,
        output s_ready
    );
endinterface

// File: rtl/approx_error_monitor.sv
// rtl/approx_error_monitor.sv - recomputes exact products and accumulates approximate-multiplier error statistics
module approx_error_monitor #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16,
    parameter int ACC_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    approx_error_monitor_if.slave     s,
    input  logic                      clear,
    output logic [CNT_W-1:0]          stat_samples,
    output logic [CNT_W-1:0]          stat_errors,
    output logic [ACC_W-1:0]          stat_ed_sum,
    output logic [2*WIDTH-1:0]        stat_ed_max,
    output logic                      stat_valid,
    output logic                      saturated
);
    localparam int PW = 2 * WIDTH;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

    typedef enum logic [1:0] {RUN, SAT, CLR} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] acc_cnt;
    logic             v1;
    logic [PW-1:0]    exact_q;
    logic [PW-1:0]    approx_q;
    logic [PW-1:0]    ed;
    logic [ACC_W:0]   sum_wide;
    logic             flush;
    logic             fire;

    always_comb begin
        state_next = state;
        s.s_ready  = 1'b0;
        flush      = 1'b0;
        case (state)
            RUN: begin
                s.s_ready = !clear && (acc_cnt != CNT_MAX);
                if (clear)
                    state_next = CLR;
                else if (stat_samples == CNT_MAX)
                    state_next = SAT;
            end
            SAT: begin
                if (clear)
                    state_next = CLR;
            end
            CLR: begin
                flush      = 1'b1;
                state_next = RUN;
            end
            default: state_next = RUN;
        endcase
        // clear drops whatever sits in S1 on the pulse edge itself, not just during CLR
        if (clear)
            flush = 1'b1;
    end

    assign fire     = s.s_valid && s.s_ready;
    assign ed       = (exact_q >= approx_q) ? (exact_q - approx_q) : (approx_q - exact_q);
    assign sum_wide = {1'b0, stat_ed_sum} + (ACC_W+1)'(ed);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            acc_cnt      <= '0;
            v1           <= 1'b0;
            exact_q      <= '0;
            approx_q     <= '0;
            stat_samples <= '0;
            stat_errors  <= '0;
            stat_ed_sum  <= '0;
            stat_ed_max  <= '0;
        end else begin
            state <= state_next;
            if (flush) begin
                acc_cnt      <= '0;
                v1           <= 1'b0;
                stat_samples <= '0;
                stat_errors  <= '0;
                stat_ed_sum  <= '0;
                stat_ed_max  <= '0;
            end else begin
                v1 <= fire;
                if (fire) begin
                    exact_q  <= PW'(s.s_in1) * PW'(s.s_in2);
                    approx_q <= s.s_approx;
                    acc_cnt  <= acc_cnt + 1'b1;
                end
                if (v1) begin
                    stat_samples <= stat_samples + 1'b1;
                    if (ed != '0)
                        stat_errors <= stat_errors + 1'b1;
                    stat_ed_sum <= sum_wide[ACC_W] ? ACC_MAX : sum_wide[ACC_W-1:0];
                    if (ed > stat_ed_max)
                        stat_ed_max <= ed;
                end
            end
        end
    end

    assign stat_valid = !v1 && (stat_samples != '0);
    assign saturated  = (state == SAT);
endmodule

// File: tb/tb_approx_error_monitor.sv
// tb/tb_approx_error_monitor.sv - scoreboard bench for approx_error_monitor
module tb_approx_error_monitor;
    localparam int WIDTH = 4;
    localparam int CNT_W = 4;
    localparam int ACC_W = 32;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 clear = 1'b0;
    logic [CNT_W-1:0]     stat_samples;
    logic [CNT_W-1:0]     stat_errors;
    logic [ACC_W-1:0]     stat_ed_sum;
    logic [2*WIDTH-1:0]   stat_ed_max;
    logic                 stat_valid;
    logic                 saturated;

    approx_error_monitor_if #(.WIDTH(WIDTH)) bus ();

    approx_error_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .s            (bus),
        .clear        (clear),
        .stat_samples (stat_samples),
        .stat_errors  (stat_errors),
        .stat_ed_sum  (stat_ed_sum),
        .stat_ed_max  (stat_ed_max),
        .stat_valid   (stat_valid),
        .saturated    (saturated)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2*WIDTH-1:0] exp_q[$];
    int unsigned        m_samples = 0;
    int unsigned        m_errors  = 0;
    longint unsigned    m_sum     = 0;
    int unsigned        m_max     = 0;
    logic [2*WIDTH-1:0] mon_ed;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_zero();
        exp_q.delete();
        m_samples = 0;
        m_errors  = 0;
        m_sum     = 0;
        m_max     = 0;
    endtask

    // Called at a falling edge; returns at the falling edge after the transfer (or after limit cycles)
    task automatic send(input int a, input int b, input int ap, input int limit, output bit ok);
        logic [2*WIDTH-1:0] ex;
        ex = 8'(a * b);
        bus.s_valid  = 1'b1;
        bus.s_in1    = 4'(a);
        bus.s_in2    = 4'(b);
        bus.s_approx = 8'(ap);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            #1;
            if (bus.s_ready) begin
                exp_q.push_back((ex >= 8'(ap)) ? ex - 8'(ap) : 8'(ap) - ex);
                ok = 1'b1;
            end
            @(negedge clk);
            if (ok) break;
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        model_zero();
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_stats(input string tag, input int smp, input int err, input int sum,
                               input int mx, input bit sv);
        check_eq({tag, "_samples"}, 64'(stat_samples), 64'(smp));
        check_eq({tag, "_errors"},  64'(stat_errors),  64'(err));
        check_eq({tag, "_ed_sum"},  64'(stat_ed_sum),  64'(sum));
        check_eq({tag, "_ed_max"},  64'(stat_ed_max),  64'(mx));
        check_eq({tag, "_stat_valid"}, 64'(stat_valid), 64'(sv));
    endtask

    // Scoreboard: every stats update pops one expected error distance
    always @(posedge clk) begin
        #1;
        if (!rst && (32'(stat_samples) != m_samples)) begin
            if (exp_q.size() == 0) begin
                check_eq("samples_unexpected", 64'(stat_samples), 64'(m_samples));
            end else begin
                mon_ed = exp_q.pop_front();
                m_samples++;
                if (mon_ed != 0) m_errors++;
                m_sum = m_sum + mon_ed;
                if (m_sum > 64'hFFFF_FFFF) m_sum = 64'hFFFF_FFFF;
                if (mon_ed > m_max) m_max = mon_ed;
                check_eq("sb_samples", 64'(stat_samples), 64'(m_samples));
                check_eq("sb_errors",  64'(stat_errors),  64'(m_errors));
                check_eq("sb_ed_sum",  64'(stat_ed_sum),  m_sum);
                check_eq("sb_ed_max",  64'(stat_ed_max),  64'(m_max));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit ok;
        int acc;
        int a, b, ex;
        bus.s_valid  = 1'b0;
        bus.s_in1    = '0;
        bus.s_in2    = '0;
        bus.s_approx = '0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_stats("reset", 0, 0, 0, 0, 0);
        check_eq("reset_ready", 64'(bus.s_ready), 1);
        check_eq("reset_saturated", 64'(saturated), 0);

        send(3, 5, 15, 4, ok);
        check_eq("t2_accept", 64'(ok), 1);
        @(negedge clk);
        check_stats("t2", 1, 0, 0, 0, 1);

        do_clear();
        send(15, 15, 200, 4, ok);
        check_eq("t3_accept0", 64'(ok), 1);
        send(15, 15, 230, 4, ok);
        check_eq("t3_accept1", 64'(ok), 1);
        repeat (2) @(negedge clk);
        check_stats("t3", 2, 2, 30, 25, 1);

        do_clear();
        for (int i = 0; i < 10; i++) begin
            a  = $urandom_range(0, 15);
            b  = $urandom_range(0, 15);
            ex = a * b;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(a, b, (i == 2 || i == 5 || i == 8) ? ex + 1 : ex, 4, ok);
            check_eq("t4_accept", 64'(ok), 1);
        end
        repeat (2) @(negedge clk);
        check_stats("t4", 10, 3, 3, 1, 1);

        do_clear();
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            send(i % 16, 3, (i % 16) * 3, 2, ok);
            if (ok) acc++;
        end
        check_eq("t5_accepted", 64'(acc), 15);
        for (int i = 0; i < 10 && !saturated; i++) @(negedge clk);
        check_eq("t5_saturated", 64'(saturated), 1);
        check_eq("t5_ready_low", 64'(bus.s_ready), 0);
        check_stats("t5_full", 15, 0, 0, 0, 1);
        @(negedge clk);
        clear = 1'b1;
        model_zero();
        @(negedge clk);
        clear = 1'b0;
        #1;
        check_eq("t5_clr_ready", 64'(bus.s_ready), 0);
        @(negedge clk);
        #1;
        check_eq("t5_run_ready", 64'(bus.s_ready), 1);
        check_eq("t5_unsaturated", 64'(saturated), 0);
        check_stats("t5_cleared", 0, 0, 0, 0, 0);

        @(negedge clk);
        send(1, 2, 2, 4, ok);
        check_eq("t6_accept", 64'(ok), 1);
        bus.s_valid  = 1'b1;
        bus.s_in1    = 4'd7;
        bus.s_in2    = 4'd7;
        bus.s_approx = 8'd49;
        clear = 1'b1;
        model_zero();
        #1;
        check_eq("t6_clear_ready", 64'(bus.s_ready), 0);
        @(negedge clk);
        clear = 1'b0;
        bus.s_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_stats("t6_clear", 0, 0, 0, 0, 0);

        send(2, 3, 7, 4, ok);
        send(4, 4, 16, 4, ok);
        repeat (2) @(negedge clk);
        send(5, 5, 20, 4, ok);
        rst = 1'b1;
        model_zero();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_stats("t6_rst", 0, 0, 0, 0, 0);
        check_eq("t6_rst_saturated", 64'(saturated), 0);
        check_eq("t6_rst_ready", 64'(bus.s_ready), 1);
        repeat (3) @(negedge clk);
        check_eq("t6_rst_samples_late", 64'(stat_samples), 0);
        check_eq("t6_queue_empty", 64'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
